// File: rtl/tl_scratchpad_bank.sv
// ---------------------------------------------------------------------------
// tl_scratchpad_bank
// Single-ported scratchpad behind a TileLink-UL style A/D channel pair.
// Puts (full/partial) write one word per A beat; Gets read one word per cycle
// into a 2-entry D response FIFO. One request is in flight at a time.
//
// Ports
//   clock, reset                 sole clock; async active-low reset
//   auto_in_a_*                  request channel (ready out, rest in)
//   auto_in_d_*                  response channel (ready in, rest out)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a new request; a Put writes its first beat here
// WRITE  | accepting the remaining beats of a multi-beat Put
// READ   | issuing one array read per cycle into the D FIFO
// ACK    | waiting for FIFO space to push the AccessAck of a Put
// ---------------------------------------------------------------------------
module tl_scratchpad_bank #(
    parameter int DATA_BYTES  = 8,
    parameter int DEPTH       = 4096,
    parameter int MAX_BEATS   = 8,
    parameter int ADDR_BITS   = 28,
    parameter int SOURCE_BITS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    output logic                      auto_in_a_ready,
    input  logic                      auto_in_a_valid,
    input  logic [2:0]                auto_in_a_bits_opcode,
    input  logic [2:0]                auto_in_a_bits_param,
    input  logic [2:0]                auto_in_a_bits_size,
    input  logic [SOURCE_BITS-1:0]    auto_in_a_bits_source,
    input  logic [ADDR_BITS-1:0]      auto_in_a_bits_address,
    input  logic [DATA_BYTES-1:0]     auto_in_a_bits_mask,
    input  logic [8*DATA_BYTES-1:0]   auto_in_a_bits_data,
    input  logic                      auto_in_a_bits_corrupt,
    input  logic                      auto_in_d_ready,
    output logic                      auto_in_d_valid,
    output logic [2:0]                auto_in_d_bits_opcode,
    output logic [2:0]                auto_in_d_bits_size,
    output logic [SOURCE_BITS-1:0]    auto_in_d_bits_source,
    output logic [8*DATA_BYTES-1:0]   auto_in_d_bits_data
);

    localparam int DW        = 8 * DATA_BYTES;
    localparam int OFF_BITS  = $clog2(DATA_BYTES);
    localparam int IDX_BITS  = $clog2(DEPTH);
    localparam int BEAT_BITS = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_ACK} state_t;

    state_t                  state_q;
    logic                    a_ready_q;
    logic [BEAT_BITS-1:0]    beat_q;
    logic [BEAT_BITS-1:0]    last_q;
    logic [2:0]              size_q;
    logic [SOURCE_BITS-1:0]  source_q;
    logic [IDX_BITS-1:0]     base_q;

    logic [DW-1:0]           mem_q [DEPTH];

    logic [1:0]              fifo_cnt_q;
    logic                    fifo_wr_q;
    logic                    fifo_rd_q;
    logic                    fifo_ack_data_q [2];
    logic [2:0]              fifo_size_q     [2];
    logic [SOURCE_BITS-1:0]  fifo_source_q   [2];
    logic [DW-1:0]           fifo_data_q     [2];

    logic                    a_fire;
    logic                    is_get;
    logic [BEAT_BITS-1:0]    req_last;
    logic [IDX_BITS-1:0]     req_idx;
    logic [IDX_BITS-1:0]     word_idx;
    logic                    wr_en;
    logic                    fifo_space;
    logic                    rd_issue;
    logic                    ack_push;
    logic                    push;
    logic                    pop;
    logic                    d_valid;
    logic                    unused_bits;

    // param is ignored and only the index slice of the address is used
    assign unused_bits = ^{auto_in_a_bits_param, auto_in_a_bits_address};

    assign a_fire   = auto_in_a_valid && a_ready_q;
    assign is_get   = (auto_in_a_bits_opcode == 3'd4);
    assign req_idx  = auto_in_a_bits_address[OFF_BITS +: IDX_BITS];

    always_comb begin
        req_last = '0;
        if (int'(auto_in_a_bits_size) > OFF_BITS) begin
            req_last = BEAT_BITS'((1 << (int'(auto_in_a_bits_size) - OFF_BITS)) - 1);
        end
    end

    // In IDLE the first Put beat indexes straight off the incoming address;
    // later beats and all reads use the latched base plus beat (mod DEPTH).
    assign word_idx = (state_q == S_IDLE) ? req_idx
                                          : base_q + IDX_BITS'(beat_q);
    assign wr_en    = a_fire && !is_get_or_later() && !auto_in_a_bits_corrupt;

    function automatic logic is_get_or_later();
        return (state_q == S_IDLE) && is_get;
    endfunction

    // Array reads land directly in the FIFO one cycle after issue, so FIFO
    // occupancy already counts every read in flight. Issuing only while the
    // FIFO is not full keeps push-with-pop-at-full from ever happening.
    assign d_valid    = (fifo_cnt_q != 2'd0);
    assign fifo_space = (fifo_cnt_q != 2'd2);
    assign rd_issue   = (state_q == S_READ) && fifo_space;
    assign ack_push   = (state_q == S_ACK) && fifo_space;
    assign push       = rd_issue || ack_push;
    assign pop        = d_valid && auto_in_d_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            a_ready_q <= 1'b0;
            beat_q    <= '0;
            last_q    <= '0;
            size_q    <= '0;
            source_q  <= '0;
            base_q    <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    a_ready_q <= 1'b1;
                    if (a_fire) begin
                        size_q   <= auto_in_a_bits_size;
                        source_q <= auto_in_a_bits_source;
                        base_q   <= req_idx;
                        last_q   <= req_last;
                        if (is_get) begin
                            state_q   <= S_READ;
                            a_ready_q <= 1'b0;
                            beat_q    <= '0;
                        end else if (req_last == '0) begin
                            state_q   <= S_ACK;
                            a_ready_q <= 1'b0;
                            beat_q    <= '0;
                        end else begin
                            state_q   <= S_WRITE;
                            beat_q    <= BEAT_BITS'(1);
                        end
                    end
                end
                S_WRITE: begin
                    if (a_fire) begin
                        if (beat_q == last_q) begin
                            state_q   <= S_ACK;
                            a_ready_q <= 1'b0;
                            beat_q    <= '0;
                        end else begin
                            beat_q    <= beat_q + BEAT_BITS'(1);
                        end
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        if (beat_q == last_q) begin
                            state_q   <= S_IDLE;
                            a_ready_q <= 1'b1;
                            beat_q    <= '0;
                        end else begin
                            beat_q    <= beat_q + BEAT_BITS'(1);
                        end
                    end
                end
                S_ACK: begin
                    if (ack_push) begin
                        state_q   <= S_IDLE;
                        a_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    a_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Storage and FIFO payload: no reset; payload is masked by d_valid.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (auto_in_a_bits_mask[b]) begin
                    mem_q[word_idx][8*b +: 8] <= auto_in_a_bits_data[8*b +: 8];
                end
            end
        end
        if (rd_issue) begin
            fifo_data_q[fifo_wr_q] <= mem_q[word_idx];
        end else if (ack_push) begin
            fifo_data_q[fifo_wr_q] <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fifo_cnt_q <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_ack_data_q[i] <= 1'b0;
                fifo_size_q[i]     <= '0;
                fifo_source_q[i]   <= '0;
            end
        end else begin
            if (push) begin
                fifo_ack_data_q[fifo_wr_q] <= rd_issue;
                fifo_size_q[fifo_wr_q]     <= size_q;
                fifo_source_q[fifo_wr_q]   <= source_q;
                fifo_wr_q                  <= ~fifo_wr_q;
            end
            if (pop) begin
                fifo_rd_q <= ~fifo_rd_q;
            end
            unique case ({push, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    assign auto_in_a_ready       = a_ready_q;
    assign auto_in_d_valid       = d_valid;
    assign auto_in_d_bits_opcode = d_valid ? {2'b00, fifo_ack_data_q[fifo_rd_q]} : 3'd0;
    assign auto_in_d_bits_size   = d_valid ? fifo_size_q[fifo_rd_q] : 3'd0;
    assign auto_in_d_bits_source = d_valid ? fifo_source_q[fifo_rd_q] : '0;
    assign auto_in_d_bits_data   = d_valid ? fifo_data_q[fifo_rd_q] : '0;

endmodule

// File: doc/tl_scratchpad_bank.md
TL_SCRATCHPAD_BANK -- requirements
Module: tl_scratchpad_bank

Interface
REQ-001 Parameter DATA_BYTES, default 8: bytes per beat; power of two.
REQ-002 Parameter DEPTH, default 4096: words in the internal array; power of two.
REQ-003 Parameter MAX_BEATS, default 8: maximum beats per burst; power of two.
REQ-004 Parameter ADDR_BITS, default 28: address width.
REQ-005 Parameter SOURCE_BITS, default 4: source ID width.
REQ-006 clock  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-008 auto_in_a_ready  out  1  A-channel ready.
REQ-009 auto_in_a_valid  in  1  A-channel valid.
REQ-010 auto_in_a_bits_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get.
REQ-011 auto_in_a_bits_param  in  3  ignored.
REQ-012 auto_in_a_bits_size  in  3  log2 of transfer bytes.
REQ-013 auto_in_a_bits_source  in  SOURCE_BITS  requester ID.
REQ-014 auto_in_a_bits_address  in  ADDR_BITS  byte address, aligned to the transfer size.
REQ-015 auto_in_a_bits_mask  in  DATA_BYTES  byte-lane write enables.
REQ-016 auto_in_a_bits_data  in  8*DATA_BYTES  write data.
REQ-017 auto_in_a_bits_corrupt  in  1  beat-corrupt flag.
REQ-018 auto_in_d_ready  in  1  D-channel ready.
REQ-019 auto_in_d_valid  out  1  D-channel valid.
REQ-020 auto_in_d_bits_opcode  out  3  0=AccessAck, 1=AccessAckData.
REQ-021 auto_in_d_bits_size  out  3  request size, echoed.
REQ-022 auto_in_d_bits_source  out  SOURCE_BITS  request source, echoed.
REQ-023 auto_in_d_bits_data  out  8*DATA_BYTES  read data; 0 on AccessAck.

Function
REQ-024 Beats per request SHALL be max(1, 2^size/DATA_BYTES); sizes above log2(DATA_BYTES*MAX_BEATS) are illegal stimulus.
REQ-025 Word index SHALL be address[log2(DATA_BYTES) +: log2(DEPTH)] + beat, wrapping modulo DEPTH; higher address bits are ignored.
REQ-026 FSM states SHALL be IDLE, WRITE, READ and ACK.
REQ-027 IDLE: a_ready=1; a Get fire goes to READ, and a Put fire writes beat 0 and goes to WRITE, or to ACK if it is the last beat.
REQ-028 WRITE: a_ready=1; each fire writes the next beat, and the last beat goes to ACK.
REQ-029 Opcode, size and source SHALL be latched from the first beat; those fields on later beats are ignored.
REQ-030 A write SHALL update only byte lanes with mask=1; a beat with corrupt=1 SHALL write nothing but still counts as a beat.
REQ-031 READ: a_ready=0; issue one synchronous array read per cycle while (FIFO count + in-flight reads − dequeue this cycle) < 2.
REQ-032 READ: after the last read is issued, go to IDLE.
REQ-033 Read data SHALL enter the D FIFO exactly one cycle after issue.
REQ-034 ACK: a_ready=0; push one AccessAck (data=0) into the FIFO when space allows, then go to IDLE.
REQ-035 The D FIFO SHALL hold 2 entries, drive d_valid=1 whenever it is non-empty, and pop on d_valid && d_ready.
REQ-036 An entry SHALL stay stable while d_valid=1 and d_ready=0.
REQ-037 Get latency: A fire at cycle t gives first d_valid at t+2.
REQ-038 With d_ready held at 1, a Get SHALL deliver one beat per cycle with no bubbles.
REQ-039 Put latency: last A beat fires at t gives d_valid at t+2, assuming FIFO space.
REQ-040 At most one request SHALL be outstanding in the FSM; a new A SHALL be accepted only in IDLE, including the cycle the FIFO still drains a prior response.
REQ-041 A Get following a Put to the same word SHALL return the new data.
REQ-042 A simultaneous FIFO push and pop when full SHALL be impossible by construction (REQ-031, REQ-034).
REQ-043 A simultaneous push and pop at count 1 SHALL leave count at 1.
REQ-044 The array SHALL be plain storage with no reset.

Reset
REQ-045 While reset=0: FSM=IDLE, beat counter=0, FIFO empty, in-flight=0, d_valid=0, a_ready=0.
REQ-046 a_ready SHALL rise to 1 on the first clock edge after reset deasserts.
REQ-047 Reset mid-burst SHALL abandon the request; array words already written keep their values, and no response is emitted.
REQ-048 All D output fields other than d_valid SHALL read 0 out of reset.

Verification
REQ-049 Single-beat PutFull, size=3, addr=0x40, data=0x1122334455667788, mask=0xFF, then a Get of the same -> AccessAck at t+2, then AccessAckData with that data and matching source.
REQ-050 8-beat Get, size=6, addr=0x100, d_ready=1 -> 8 consecutive d_valid beats starting at t+2 returning words 0x20..0x27, with d_size=6 on every beat.
REQ-051 Same Get with d_ready toggled 1/0 per cycle -> 8 beats in order, none dropped or duplicated, data stable while stalled.
REQ-052 PutPartial mask=0x0F data=0xAAAAAAAABBBBBBBB over a word holding 0 -> a read returns 0x00000000BBBBBBBB; a beat with corrupt=1 leaves the word unchanged.
REQ-053 reset=0 during beat 3 of a 4-beat Put -> d_valid=0 at once, no ack after release, beats 0-2 written, beat 3 not written.
REQ-054 Address 0x8000 with DEPTH=4096, DATA_BYTES=8 -> aliases word 0 (wrap check).
